// File: rtl/decoder_5to32.sv
`timescale 1ns/1ps
// 5-to-32 one-hot decoder with enable gating, plus a registered copy
// of the decode and a registered valid flag.
module decoder_5to32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [4:0]  select,
    output logic [31:0] out_data,
    output logic [31:0] out_reg,
    output logic        out_valid
);

    // Compare-per-bit rather than a shift, so an unknown select or enable
    // resolves to all-zero instead of a partial or multi-hot vector.
    always_comb begin
        out_data = 32'h0000_0000;
        if (enable) begin
            for (int i = 0; i < 32; i++) begin
                if (select == 5'(i)) begin
                    out_data[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg   <= 32'h0000_0000;
            out_valid <= 1'b0;
        end else begin
            out_reg   <= out_data;
            out_valid <= enable;
        end
    end

endmodule

// File: tb/tb_decoder_5to32.sv
`timescale 1ns/1ps
// Self-checking bench for decoder_5to32: vector table, scoreboard for the
// registered outputs, and directed mid-cycle sequences.
module tb_decoder_5to32;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [4:0]  select;
    logic [31:0] out_data;
    logic [31:0] out_reg;
    logic        out_valid;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  sel;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] reg_v;
        logic        valid;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[10];
    int          total = 0;
    int          bad = 0;
    bit          clk_run = 1'b1;
    logic [31:0] last_reg;

    decoder_5to32 dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .select   (select),
        .out_data (out_data),
        .out_reg  (out_reg),
        .out_valid(out_valid)
    );

    initial clock = 1'b0;
    always begin
        #5;
        if (clk_run) clock = ~clock;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs and push the value the registers must hold after the next edge.
    task automatic drive(input logic r, input logic e, input logic [4:0] s);
        exp_t x;
        reset  = r;
        enable = e;
        select = s;
        x.reg_v = (r || !e) ? 32'h0 : (32'h1 << s);
        x.valid = !r && e;
        sb_q.push_back(x);
        last_reg = x.reg_v;
    endtask

    task automatic edge_check(input string name);
        exp_t x;
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
        end else begin
            x = sb_q.pop_front();
            check32({name, "_reg"}, out_reg, x.reg_v);
            check1({name, "_valid"}, out_valid, x.valid);
        end
    endtask

    // Continuous one-hot / popcount checker on the combinational output.
    always @(enable or select or out_data) begin
        #1;
        if (!$isunknown({enable, select})) begin
            total++;
            if ($countones(out_data) != (enable ? 1 : 0)) begin
                bad++;
                $display("FAIL onehot: got %h expected popcount %0d at t=%0t",
                         out_data, enable ? 1 : 0, $time);
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd0,  32'h0000_0001};
        vecs[1] = '{1'b0, 1'b1, 5'd31, 32'h8000_0000};
        vecs[2] = '{1'b0, 1'b1, 5'd5,  32'h0000_0020};
        vecs[3] = '{1'b0, 1'b0, 5'd0,  32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 5'd15, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b0, 5'd31, 32'h0000_0000};
        vecs[6] = '{1'b1, 1'b1, 5'd7,  32'h0000_0080};
        vecs[7] = '{1'b0, 1'b1, 5'd31, 32'h8000_0000};
        vecs[8] = '{1'b0, 1'b1, 5'd16, 32'h0001_0000};
        vecs[9] = '{1'b0, 1'b1, 5'd3,  32'h0000_0008};

        // Initial reset
        drive(1'b1, 1'b0, 5'd0);
        edge_check("reset");

        foreach (vecs[k]) begin
            @(negedge clock);
            drive(vecs[k].rst, vecs[k].en, vecs[k].sel);
            #1;
            check32($sformatf("vec%0d_data", k), out_data, vecs[k].exp_data);
            edge_check($sformatf("vec%0d", k));
        end

        // Sweep with the clock stopped: out_data tracks select, out_reg holds.
        @(negedge clock);
        clk_run = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            select = 5'(i);
            #10;
            check32($sformatf("sweep%0d_data", i), out_data, 32'h1 << i);
        end
        check32("sweep_hold_reg", out_reg, last_reg);
        clk_run = 1'b1;

        // Capture select=31, then move select mid-cycle.
        @(negedge clock);
        drive(1'b0, 1'b1, 5'd31);
        edge_check("sel31");
        #2;
        select = 5'd0;
        #1;
        check32("mid_sel0_data", out_data, 32'h0000_0001);
        check32("mid_sel0_hold", out_reg, 32'h8000_0000);
        sb_q.push_back('{32'h0000_0001, 1'b1});
        edge_check("sel0_next");

        // Enable drop mid-cycle with select=16.
        @(negedge clock);
        drive(1'b0, 1'b1, 5'd16);
        #1;
        check32("en_hi_data", out_data, 32'h0001_0000);
        edge_check("sel16");
        #2;
        enable = 1'b0;
        #0;
        check32("en_drop_data", out_data, 32'h0000_0000);
        check32("en_drop_hold", out_reg, 32'h0001_0000);
        sb_q.push_back('{32'h0000_0000, 1'b0});
        edge_check("en_drop_next");

        // Only the select value present at the edge is captured.
        @(negedge clock);
        enable = 1'b1;
        select = 5'd3;
        #2;
        drive(1'b0, 1'b1, 5'd9);
        edge_check("last_sel");

        // Enable and select change together.
        @(negedge clock);
        drive(1'b0, 1'b0, 5'd20);
        edge_check("both_off");
        @(negedge clock);
        drive(1'b0, 1'b1, 5'd27);
        edge_check("both_on");

        // Reset for one edge, then resume on the next.
        @(negedge clock);
        drive(1'b1, 1'b1, 5'd12);
        #1;
        check32("rst_data", out_data, 32'h0000_1000);
        edge_check("rst_again");
        @(negedge clock);
        drive(1'b0, 1'b1, 5'd12);
        edge_check("post_rst");

        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
